// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and carry-seed helper for the serial ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADDC  = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_SUBB  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd7;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd8;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Carry fed into the least significant slice: SUB needs the +1 of two's complement.
  function automatic logic init_carry(input logic [OP_W-1:0] op, input logic cin);
    case (op)
      OP_ADDC, OP_SUBB: return cin;
      OP_SUB:           return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; chained through a registered carry by the top.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [OP_W-1:0]  sel,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  localparam int unsigned SW = SLICE + 1;

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;
  logic             arith;

  // Opcode decode; logic ops and unused codes leave the carries at zero.
  always_comb begin
    b_eff = b;
    arith = 1'b0;
    s     = '0;
    cout  = 1'b0;
    c_msb = 1'b0;
    case (sel)
      OP_ADD, OP_ADDC: arith = 1'b1;
      OP_SUB, OP_SUBB: begin
        arith = 1'b1;
        b_eff = ~b;
      end
      OP_AND:   s = a & b;
      OP_OR:    s = a | b;
      OP_XOR:   s = a ^ b;
      OP_NOT:   s = ~a;
      OP_PASSA: s = a;
      OP_PASSB: s = b;
      default:  s = '0;
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + SW'(cin);
    if (arith) begin
      s     = sum[SLICE-1:0];
      cout  = sum[SLICE];
      // Carry into the slice MSB, recovered from the MSB sum bit.
      c_msb = a[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
    end
  end

endmodule

// File: rtl/alu_serial_param.sv
// Digit-serial ALU: WIDTH-bit operation computed SLICE bits per clock, valid/ready on both sides.
module alu_serial_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [OP_W-1:0]  sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  sel_q, sel_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             load;

  logic [SLICE-1:0] sl_s;
  logic             sl_cout;
  logic             sl_c_msb;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .cin   (carry_q),
    .sel   (sel_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_c_msb)
  );

  // Releasing a taken result and accepting the next operand set happen in the same cycle.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_valid_q && out_ready);
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Next-state, datapath shifting and flag accumulation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    carry_d     = carry_q;
    s_d         = s_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: load = in_valid;
      ST_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        s_d     = (s_q >> SLICE) | (WIDTH'(sl_s) << (WIDTH - SLICE));
        carry_d = sl_cout;
        zero_d  = zero_q & ~(|sl_s);
        if (cnt_q == CNT_LAST) begin
          ovf_d   = sl_c_msb ^ sl_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          load        = in_valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      a_d     = a;
      b_d     = b;
      sel_d   = sel;
      carry_d = init_carry(sel, cin);
      zero_d  = 1'b1;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      carry_q     <= 1'b0;
      s_q         <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      carry_q     <= carry_d;
      s_q         <= s_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_serial_param.sv
// Scoreboard bench for alu_serial_param across several WIDTH/SLICE configurations.
module tb_alu_serial_param;
  import alu_pkg::*;

  localparam int NI = 5;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  localparam int NV = 10;
  localparam vec_t VECS [NV] = '{
    '{OP_ADD,   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
    '{OP_SUB,   8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{OP_ADDC,  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{OP_ADD,   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{OP_SUB,   8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0},
    '{OP_SUBB,  8'h10, 8'h01, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0},
    '{OP_AND,   8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0},
    '{OP_PASSB, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0},
    '{OP_NOT,   8'h0F, 8'h55, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0},
    '{4'd11,    8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1}
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_v  [NI];
  logic        in_ready_v  [NI];
  logic [15:0] a_v         [NI];
  logic [15:0] b_v         [NI];
  logic        cin_v       [NI];
  logic [3:0]  sel_v       [NI];
  logic        out_valid_v [NI];
  logic        out_ready_v [NI];
  logic [15:0] s_v         [NI];
  logic        cout_v      [NI];
  logic        ovf_v       [NI];
  logic        zero_v      [NI];

  res_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Instances 0..3: WIDTH=8 with SLICE 1,2,4,8; instance 4: WIDTH=16, SLICE=4.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W  = (g == 4) ? 16 : 8;
    localparam int unsigned SL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
    logic [W-1:0] s_w;
    alu_serial_param #(.WIDTH(W), .SLICE(SL)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g][W-1:0]),
      .b         (b_v[g][W-1:0]),
      .cin       (cin_v[g]),
      .sel       (sel_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .s         (s_w),
      .cout      (cout_v[g]),
      .ovf       (ovf_v[g]),
      .zero      (zero_v[g])
    );
    assign s_v[g] = 16'(s_w);
  end

  function automatic int width_of(input int k);
    return (k == 4) ? 16 : 8;
  endfunction

  // Whole-word reference: plain binary add on masked operands.
  function automatic res_t ref_model(input int k, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic [3:0] sel);
    int          w;
    logic [15:0] m, am, bm, be;
    logic [16:0] sum;
    logic        c0;
    bit          arith;
    res_t        r;
    w = width_of(k);
    m = 16'((17'd1 << w) - 17'd1);
    am = a & m;
    bm = b & m;
    be = bm;
    c0 = 1'b0;
    arith = 1'b0;
    r = '0;
    case (sel)
      OP_ADD:   arith = 1'b1;
      OP_ADDC:  begin arith = 1'b1; c0 = cin; end
      OP_SUB:   begin arith = 1'b1; be = ~bm & m; c0 = 1'b1; end
      OP_SUBB:  begin arith = 1'b1; be = ~bm & m; c0 = cin; end
      OP_AND:   r.s = am & bm;
      OP_OR:    r.s = am | bm;
      OP_XOR:   r.s = am ^ bm;
      OP_NOT:   r.s = ~am & m;
      OP_PASSA: r.s = am;
      OP_PASSB: r.s = bm;
      default:  r.s = '0;
    endcase
    if (arith) begin
      sum    = {1'b0, am} + {1'b0, be} + 17'(c0);
      r.s    = sum[15:0] & m;
      r.cout = sum[w];
      r.ovf  = (am[w-1] ^ be[w-1] ^ sum[w-1]) ^ r.cout;
    end
    r.zero = (r.s == 16'h0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set and holds it until accepted (bounded).
  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [3:0] sel);
    bit done;
    done = 1'b0;
    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sel_v[k] = sel;
    in_valid_v[k] = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (in_ready_v[k] === 1'b1) done = 1'b1;
      tick();
    end
    in_valid_v[k] = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL issue_timeout k=%0d in_ready=%b want 1 within 50 cycles", k, in_ready_v[k]);
    end
  endtask

  // Counts edges after the accepting edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(input int k, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (out_valid_v[k] === 1'b1) begin
        lat = i;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b1;
      a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sel_v[k] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({in_ready_v[k], out_valid_v[k], s_v[k], cout_v[k], ovf_v[k], zero_v[k]} !==
          {1'b1, 1'b0, 16'h0000, 3'b000}) begin
        n_bad++;
        $display("FAIL reset k=%0d rdy=%b vld=%b s=%h c=%b v=%b z=%b want 1 0 0000 0 0 0",
                 k, in_ready_v[k], out_valid_v[k], s_v[k], cout_v[k], ovf_v[k], zero_v[k]);
      end
    end
  endtask

  task automatic test_arith();
    int   lat;
    res_t g, e;
    exp_q.delete();
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(res_t'{16'(VECS[i].s), VECS[i].cout, VECS[i].ovf, VECS[i].zero});
      issue(1, 16'(VECS[i].a), 16'(VECS[i].b), VECS[i].cin, VECS[i].sel);
      wait_out(1, lat);
      n_cmp++;
      if (lat != 5) begin
        n_bad++;
        $display("FAIL arith_latency[%0d] got %0d want 5", i, lat);
      end
      g = {s_v[1], cout_v[1], ovf_v[1], zero_v[1]};
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL arith[%0d] got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                 i, g.s, g.cout, g.ovf, g.zero, e.s, e.cout, e.ovf, e.zero);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    res_t g, e;
    exp_q.delete();
    out_ready_v[1] = 1'b0;
    exp_q.push_back(res_t'{16'h0030, 1'b0, 1'b0, 1'b0});
    issue(1, 16'h00F0, 16'h003C, 1'b0, OP_AND);
    wait_out(1, lat);
    n_cmp++;
    if (lat != 5) begin
      n_bad++;
      $display("FAIL bp_latency got %0d want 5", lat);
    end
    for (int i = 0; i < 3; i++) begin
      a_v[1] = 16'h0000; b_v[1] = 16'h000F; sel_v[1] = OP_OR; in_valid_v[1] = 1'b1;
      tick();
      #1;
      n_cmp++;
      if ({out_valid_v[1], in_ready_v[1], s_v[1], cout_v[1], ovf_v[1], zero_v[1]} !==
          {1'b1, 1'b0, 16'h0030, 3'b000}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] vld=%b rdy=%b s=%h c=%b v=%b z=%b want 1 0 0030 0 0 0",
                 i, out_valid_v[1], in_ready_v[1], s_v[1], cout_v[1], ovf_v[1], zero_v[1]);
      end
    end
    a_v[1] = 16'h000F; b_v[1] = 16'h00FF; sel_v[1] = OP_XOR; out_ready_v[1] = 1'b1;
    exp_q.push_back(res_t'{16'h00F0, 1'b0, 1'b0, 1'b0});
    #1;
    n_cmp++;
    if (in_ready_v[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready got %b want 1", in_ready_v[1]);
    end
    g = {s_v[1], cout_v[1], ovf_v[1], zero_v[1]};
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL bp_first got s=%h c=%b v=%b z=%b want s=%h", g.s, g.cout, g.ovf, g.zero, e.s);
    end
    tick();
    in_valid_v[1] = 1'b0;
    a_v[1] = 16'h1234; b_v[1] = 16'h5678; sel_v[1] = OP_ADD;
    wait_out(1, lat);
    n_cmp++;
    if (lat != 5) begin
      n_bad++;
      $display("FAIL bp_b2b_latency got %0d want 5", lat);
    end
    g = {s_v[1], cout_v[1], ovf_v[1], zero_v[1]};
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL bp_b2b got s=%h c=%b v=%b z=%b want s=%h", g.s, g.cout, g.ovf, g.zero, e.s);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int   lat;
    res_t g, e;
    exp_q.delete();
    issue(1, 16'h0011, 16'h0022, 1'b0, OP_ADD);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_v[1], out_valid_v[1], s_v[1], cout_v[1], ovf_v[1], zero_v[1]} !==
        {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      n_bad++;
      $display("FAIL midrun_reset rdy=%b vld=%b s=%h c=%b v=%b z=%b want 1 0 0000 0 0 0",
               in_ready_v[1], out_valid_v[1], s_v[1], cout_v[1], ovf_v[1], zero_v[1]);
    end
    exp_q.push_back(res_t'{16'h00C4, 1'b0, 1'b1, 1'b0});
    issue(1, 16'h0062, 16'h0062, 1'b0, OP_ADD);
    wait_out(1, lat);
    n_cmp++;
    if (lat != 5) begin
      n_bad++;
      $display("FAIL midrun_latency got %0d want 5", lat);
    end
    g = {s_v[1], cout_v[1], ovf_v[1], zero_v[1]};
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL midrun_after got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
               g.s, g.cout, g.ovf, g.zero, e.s, e.cout, e.ovf, e.zero);
    end
    tick();
  endtask

  task automatic test_wide();
    int   lat;
    res_t g, e;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        exp_q.push_back(res_t'{16'h5A5A, 1'b0, 1'b0, 1'b0});
        issue(4, 16'hA5A5, 16'hFFFF, 1'b0, OP_XOR);
      end else begin
        exp_q.push_back(res_t'{16'h0000, 1'b0, 1'b0, 1'b1});
        issue(4, 16'hA5A5, 16'hFFFF, 1'b1, 4'd12);
      end
      wait_out(4, lat);
      n_cmp++;
      if (lat != 5) begin
        n_bad++;
        $display("FAIL wide_latency[%0d] got %0d want 5", i, lat);
      end
      g = {s_v[4], cout_v[4], ovf_v[4], zero_v[4]};
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL wide[%0d] got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                 i, g.s, g.cout, g.ovf, g.zero, e.s, e.cout, e.ovf, e.zero);
      end
      tick();
    end
  endtask

  task automatic test_random(input int k, input int n);
    int   sent, got;
    bit   accepted;
    res_t g, e;
    sent = 0;
    got = 0;
    exp_q.delete();
    in_valid_v[k] = 1'b0;
    for (int c = 0; c < 4000 && got < n; c++) begin
      if (!in_valid_v[k] && sent < n && $urandom_range(0, 2) != 0) begin
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
        cin_v[k] = 1'($urandom); sel_v[k] = 4'($urandom_range(0, 15));
        in_valid_v[k] = 1'b1;
      end
      out_ready_v[k] = ($urandom_range(0, 3) != 0);
      #1;
      accepted = in_valid_v[k] && in_ready_v[k];
      if (accepted) begin
        exp_q.push_back(ref_model(k, a_v[k], b_v[k], cin_v[k], sel_v[k]));
        sent++;
      end
      if (out_valid_v[k] && out_ready_v[k]) begin
        g = {s_v[k], cout_v[k], ovf_v[k], zero_v[k]};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand k=%0d unexpected result s=%h with empty scoreboard", k, g.s);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL rand k=%0d #%0d got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                     k, got, g.s, g.cout, g.ovf, g.zero, e.s, e.cout, e.ovf, e.zero);
          end
        end
        got++;
      end
      tick();
      if (accepted) begin
        in_valid_v[k] = 1'b0;
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); sel_v[k] = 4'($urandom_range(0, 15));
      end
    end
    n_cmp++;
    if (got != n || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_done k=%0d got %0d results (%0d pending) want %0d", k, got, exp_q.size(), n);
    end
    out_ready_v[k] = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_midrun();
    test_wide();
    for (int k = 0; k < NI; k++) test_random(k, 60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
